// File: rtl/uart_debug_pkg.sv
// Shared definitions for the UART debug transmit scheduler:
// gray-coded state encoding, error codes and the source-tag byte format.
package uart_debug_pkg;

    // Gray-coded along the main path IDLE -> (TAG) -> LOAD -> START -> DONE.
    typedef enum logic [2:0] {
        IDLE  = 3'b000,
        TAG   = 3'b001,
        LOAD  = 3'b011,
        START = 3'b010,
        DONE  = 3'b110
    } state_t;

    localparam logic [1:0] ERR_NONE      = 2'b00;
    localparam logic [1:0] ERR_START_TMO = 2'b01;
    localparam logic [1:0] ERR_GAP_TMO   = 2'b10;

    localparam logic [5:0] TAG_PREFIX = 6'b101000;

    // Source tag sent ahead of a message when tagging is built in.
    function automatic logic [7:0] tag_byte(input logic [1:0] id);
        return {TAG_PREFIX, id};
    endfunction

endpackage

// File: rtl/uart_debug_tx_sched_if.sv
// Requester and UART-sender signals of the debug transmit scheduler.
// master: requesters plus sender model side; slave: the scheduler.
interface uart_debug_tx_sched_if;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic        grant_vld;
    logic [1:0]  grant_id;
    logic        err_pulse;
    logic [1:0]  err_code;

    modport master (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, tx_data, tx_start, grant_vld, grant_id, err_pulse, err_code
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, tx_data, tx_start, grant_vld, grant_id, err_pulse, err_code
    );
endinterface

// File: rtl/uart_debug_rr_arb.sv
// Round-robin pick among four requesters, starting just after last_id.
// last_id itself is considered last, so the previous owner has lowest priority.
module uart_debug_rr_arb #(
    parameter int NUM_REQ = 4
) (
    input  logic [3:0] req,
    input  logic [1:0] last_id,
    output logic       gnt_vld,
    output logic [1:0] gnt_id
);

    logic [1:0] idx;

    // Scan from farthest to nearest offset so the nearest set request wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = last_id;
        idx     = 2'd0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            idx = last_id + off[1:0];
            if (req[idx]) begin
                gnt_vld = 1'b1;
                gnt_id  = idx;
            end
        end
    end

endmodule

// File: rtl/uart_debug_tx_sched.sv
// UART debug transmit scheduler: round-robin grants one requester a whole
// message and feeds its bytes one at a time to a UART sender via a
// tx_start / tx_busy handshake, with start and inter-byte timeouts.
// Build option: UART_DEBUG_SRC_TAG_EN prepends a source-tag byte
// {101000, grant_id} to every message.
//
// state | meaning
// IDLE  | no owner; arbitrate among valid requesters
// TAG   | load the source-tag byte (tag builds only)
// LOAD  | wait for the owner's next byte, accept it
// START | hold tx_start until the sender reports busy
// DONE  | wait for the sender to finish the byte
module uart_debug_tx_sched
    import uart_debug_pkg::*;
#(
    parameter int          NUM_REQ   = 4,
    parameter logic [15:0] START_TMO = 16'd4096,
    parameter logic [15:0] GAP_TMO   = 16'd65535
) (
    input  logic                   clk_uart,
    input  logic                   rst_n,
    uart_debug_tx_sched_if.slave   bus
);

    state_t      state_q, state_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_start_q, tx_start_d;
    logic        grant_vld_q, grant_vld_d;
    logic [1:0]  grant_id_q, grant_id_d;
    logic [1:0]  last_id_q, last_id_d;
    logic        last_f_q, last_f_d;
    logic        err_pulse_q, err_pulse_d;
    logic [1:0]  err_code_q, err_code_d;
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic [3:0]  req_ready_c;

    logic        arb_vld;
    logic [1:0]  arb_id;

    uart_debug_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
        .req     (bus.req_valid),
        .last_id (last_id_q),
        .gnt_vld (arb_vld),
        .gnt_id  (arb_id)
    );

    // Next-state and output logic. req_ready is combinational so the byte
    // is accepted in the same cycle its valid is seen in LOAD.
    always_comb begin
        state_d     = state_q;
        tx_data_d   = tx_data_q;
        tx_start_d  = tx_start_q;
        grant_vld_d = grant_vld_q;
        grant_id_d  = grant_id_q;
        last_id_d   = last_id_q;
        last_f_d    = last_f_q;
        err_pulse_d = 1'b0;
        err_code_d  = err_code_q;
        req_ready_c = 4'b0000;

        case (state_q)
            IDLE: begin
                if (arb_vld) begin
                    grant_vld_d = 1'b1;
                    grant_id_d  = arb_id;
`ifdef UART_DEBUG_SRC_TAG_EN
                    state_d     = TAG;
`else
                    state_d     = LOAD;
`endif
                end
            end
`ifdef UART_DEBUG_SRC_TAG_EN
            TAG: begin
                tx_data_d  = tag_byte(grant_id_q);
                last_f_d   = 1'b0;
                tx_start_d = 1'b1;
                state_d    = START;
            end
`endif
            LOAD: begin
                if (bus.req_valid[grant_id_q]) begin
                    req_ready_c[grant_id_q] = 1'b1;
                    tx_data_d  = bus.req_data[{grant_id_q, 3'b000} +: 8];
                    last_f_d   = bus.req_last[grant_id_q];
                    tx_start_d = 1'b1;
                    state_d    = START;
                end else if (tmo_cnt_q == (GAP_TMO - 16'd1)) begin
                    // Owner stalled mid-message: abort and demote it.
                    err_pulse_d = 1'b1;
                    err_code_d  = ERR_GAP_TMO;
                    grant_vld_d = 1'b0;
                    last_id_d   = grant_id_q;
                    state_d     = IDLE;
                end
            end
            START: begin
                if (bus.tx_busy) begin
                    tx_start_d = 1'b0;
                    state_d    = DONE;
                end else if (tmo_cnt_q == (START_TMO - 16'd1)) begin
                    // Sender never picked the byte up.
                    tx_start_d  = 1'b0;
                    err_pulse_d = 1'b1;
                    err_code_d  = ERR_START_TMO;
                    grant_vld_d = 1'b0;
                    last_id_d   = grant_id_q;
                    state_d     = IDLE;
                end
            end
            DONE: begin
                if (!bus.tx_busy) begin
                    if (last_f_q) begin
                        grant_vld_d = 1'b0;
                        last_id_d   = grant_id_q;
                        state_d     = IDLE;
                    end else begin
                        state_d     = LOAD;
                    end
                end
            end
            default: begin
                tx_start_d  = 1'b0;
                grant_vld_d = 1'b0;
                state_d     = IDLE;
            end
        endcase

        // Timeout counter restarts on every state change and only runs
        // while waiting on the requester (LOAD) or the sender (START).
        if (state_d != state_q) begin
            tmo_cnt_d = 16'd0;
        end else if (state_q == LOAD || state_q == START) begin
            tmo_cnt_d = tmo_cnt_q + 16'd1;
        end else begin
            tmo_cnt_d = tmo_cnt_q;
        end
    end

    // State and registered outputs; reset abandons any transfer silently.
    always_ff @(posedge clk_uart or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tx_data_q   <= 8'h00;
            tx_start_q  <= 1'b0;
            grant_vld_q <= 1'b0;
            grant_id_q  <= 2'd0;
            last_id_q   <= 2'd3;
            last_f_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_code_q  <= ERR_NONE;
            tmo_cnt_q   <= 16'd0;
        end else begin
            state_q     <= state_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            grant_vld_q <= grant_vld_d;
            grant_id_q  <= grant_id_d;
            last_id_q   <= last_id_d;
            last_f_q    <= last_f_d;
            err_pulse_q <= err_pulse_d;
            err_code_q  <= err_code_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_start  = tx_start_q;
    assign bus.grant_vld = grant_vld_q;
    assign bus.grant_id  = grant_id_q;
    assign bus.err_pulse = err_pulse_q;
    assign bus.err_code  = err_code_q;

endmodule

// File: tb/tb_uart_debug_tx_sched.sv
// Directed testbench for uart_debug_tx_sched with requester queues and a
// simple UART sender model. Short timeouts keep the run small.
module tb_uart_debug_tx_sched;

    localparam logic [15:0] START_TMO = 16'd12;
    localparam logic [15:0] GAP_TMO   = 16'd20;

    typedef logic [8:0] byteq_t[$];
    typedef logic [7:0] bq_t[$];

    logic clk_uart = 1'b0;
    logic rst_n    = 1'b0;

    always #5 clk_uart = ~clk_uart;

    uart_debug_tx_sched_if bus();

    uart_debug_tx_sched #(
        .NUM_REQ   (4),
        .START_TMO (START_TMO),
        .GAP_TMO   (GAP_TMO)
    ) dut (
        .clk_uart (clk_uart),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    byteq_t     rq[4];
    bq_t        tx_log;
    logic [1:0] gnt_log[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0, snd_cnt = 0, st_cnt = 0, err_cnt = 0;
    int err_cyc = 0, fall_cyc = 0, gv_fall_cyc = 0, viol = 0;
    int rdy_cnt[4];
    logic       snd_en  = 1'b0;
    logic       gv_prev = 1'b0;
    logic [3:0] acc     = 4'b0000;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit q_empty();
        return rq[0].size() == 0 && rq[1].size() == 0 && rq[2].size() == 0 && rq[3].size() == 0;
    endfunction

    // Requesters, sender model and monitors, all stepped on the falling edge.
    initial begin
        logic [3:0]  v;
        logic [31:0] d;
        logic [3:0]  l;
        logic [8:0]  h;
        for (int i = 0; i < 4; i++) rdy_cnt[i] = 0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.tx_busy   = 1'b0;
        forever begin
            @(negedge clk_uart);
            cyc++;
            if (bus.grant_vld && !gv_prev) gnt_log.push_back(bus.grant_id);
            if (!bus.grant_vld && gv_prev) gv_fall_cyc = cyc;
            gv_prev = bus.grant_vld;
            if (bus.tx_start) st_cnt++;
            if (bus.err_pulse) begin
                err_cnt++;
                err_cyc = cyc;
            end
            if (!snd_en) begin
                bus.tx_busy = 1'b0;
                snd_cnt = 0;
            end else if (snd_cnt == 0) begin
                if (bus.tx_start) begin
                    tx_log.push_back(bus.tx_data);
                    snd_cnt = 1;
                end
            end else begin
                snd_cnt++;
                if (snd_cnt == 2) begin
                    bus.tx_busy = 1'b1;
                end else if (snd_cnt == 5) begin
                    bus.tx_busy = 1'b0;
                    snd_cnt = 0;
                    fall_cyc = cyc;
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
            end
            v = '0;
            d = '0;
            l = '0;
            for (int i = 0; i < 4; i++) begin
                if (rq[i].size() > 0) begin
                    h = rq[i][0];
                    v[i] = 1'b1;
                    d[8*i +: 8] = h[7:0];
                    l[i] = h[8];
                end
            end
            bus.req_valid = v;
            bus.req_data  = d;
            bus.req_last  = l;
            #2;
            acc = bus.req_valid & bus.req_ready;
            for (int i = 0; i < 4; i++) if (acc[i]) rdy_cnt[i]++;
            if (bus.req_ready != 4'b0000 &&
                (!bus.grant_vld || bus.req_ready != (4'b0001 << bus.grant_id))) viol++;
        end
    end

    task automatic tick();
        @(negedge clk_uart);
        #3;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        snd_en = 1'b0;
        for (int i = 0; i < 4; i++) rq[i].delete();
        repeat (2) @(negedge clk_uart);
        #3;
        rst_n = 1'b1;
        tick();
        tx_log.delete();
        gnt_log.delete();
        for (int i = 0; i < 4; i++) rdy_cnt[i] = 0;
    endtask

    task automatic wait_quiet(input string tag);
        int n;
        n = 0;
        repeat (3) tick();
        while (!(bus.grant_vld == 1'b0 && bus.tx_busy == 1'b0 && !bus.tx_start && q_empty()) && n <= 600) begin
            tick();
            n++;
        end
        check_val({tag, " quiet timeout"}, 32'(n > 600), 32'd0);
    endtask

    task automatic wait_start(input string tag);
        int n;
        n = 0;
        while (!bus.tx_start && n <= 100) begin
            tick();
            n++;
        end
        check_val({tag, " start timeout"}, 32'(n > 100), 32'd0);
    endtask

    task automatic wait_err(input string tag, input int e0);
        int n;
        n = 0;
        while (err_cnt == e0 && n <= 300) begin
            tick();
            n++;
        end
        check_val({tag, " err timeout"}, 32'(n > 300), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, " tx_start"},  32'(bus.tx_start),  32'd0);
        check_val({tag, " tx_data"},   32'(bus.tx_data),   32'h00);
        check_val({tag, " req_ready"}, 32'(bus.req_ready), 32'd0);
        check_val({tag, " grant_vld"}, 32'(bus.grant_vld), 32'd0);
        check_val({tag, " grant_id"},  32'(bus.grant_id),  32'd0);
        check_val({tag, " err_pulse"}, 32'(bus.err_pulse), 32'd0);
        check_val({tag, " err_code"},  32'(bus.err_code),  32'd0);
    endtask

    task automatic check_log(input string tag, input bq_t exp_q);
        logic [7:0] got;
        check_val({tag, " len"}, 32'(tx_log.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++) begin
            got = (k < tx_log.size()) ? tx_log[k] : 8'hxx;
            check_val($sformatf("%s byte%0d", tag, k), 32'(got), 32'(exp_q[k]));
        end
    endtask

    // Main directed sequence.
    initial begin
        bq_t exp_q;
        int  e0;
        int  r0;

        @(negedge clk_uart);
        #1;
        check_reset_outputs("rst");

        // Requester 1: three-byte message.
        do_reset();
        snd_en = 1'b1;
        rq[1].push_back({1'b0, 8'h11});
        rq[1].push_back({1'b0, 8'h22});
        rq[1].push_back({1'b1, 8'h33});
        wait_quiet("t1");
        exp_q.delete();
`ifdef UART_DEBUG_SRC_TAG_EN
        exp_q.push_back(8'hA1);
`endif
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        check_log("t1 log", exp_q);
        check_val("t1 rdy1", 32'(rdy_cnt[1]), 32'd3);
        check_val("t1 gnt count", 32'(gnt_log.size()), 32'd1);
        check_val("t1 gnt id", 32'(gnt_log.size() > 0 ? gnt_log[0] : 2'bxx), 32'd1);
        check_val("t1 gv clear cyc", 32'(gv_fall_cyc - fall_cyc), 32'd1);
        check_val("t1 grant_vld", 32'(bus.grant_vld), 32'd0);

        // Requesters 0 and 2 collide, twice.
        do_reset();
        snd_en = 1'b1;
        rq[0].push_back({1'b1, 8'h01});
        rq[0].push_back({1'b1, 8'h03});
        rq[2].push_back({1'b1, 8'h02});
        rq[2].push_back({1'b1, 8'h04});
        wait_quiet("t2");
        check_val("t2 gnt count", 32'(gnt_log.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check_val($sformatf("t2 gnt%0d", k),
                      32'(k < gnt_log.size() ? gnt_log[k] : 2'bxx),
                      32'((k % 2 == 0) ? 0 : 2));
        end
        exp_q.delete();
`ifdef UART_DEBUG_SRC_TAG_EN
        exp_q.push_back(8'hA0); exp_q.push_back(8'h01);
        exp_q.push_back(8'hA2); exp_q.push_back(8'h02);
        exp_q.push_back(8'hA0); exp_q.push_back(8'h03);
        exp_q.push_back(8'hA2); exp_q.push_back(8'h04);
`else
        exp_q.push_back(8'h01); exp_q.push_back(8'h02);
        exp_q.push_back(8'h03); exp_q.push_back(8'h04);
`endif
        check_log("t2 log", exp_q);
        check_val("t2 rdy0", 32'(rdy_cnt[0]), 32'd2);
        check_val("t2 rdy2", 32'(rdy_cnt[2]), 32'd2);

        // Sender never goes busy: start timeout.
        do_reset();
        st_cnt = 0;
        e0 = err_cnt;
        rq[0].push_back({1'b1, 8'h77});
        wait_start("t3");
        rq[0].delete();
        wait_err("t3", e0);
        check_val("t3 err_code", 32'(bus.err_code), 32'd1);
        check_val("t3 tx_start", 32'(bus.tx_start), 32'd0);
        check_val("t3 start cycles", 32'(st_cnt), 32'(START_TMO));
        wait_quiet("t3b");
        check_val("t3 err count", 32'(err_cnt - e0), 32'd1);
        snd_en = 1'b1;
        rq[1].push_back({1'b1, 8'h99});
        wait_quiet("t3c");
        exp_q.delete();
`ifdef UART_DEBUG_SRC_TAG_EN
        exp_q.push_back(8'hA1);
`endif
        exp_q.push_back(8'h99);
        check_log("t3 served", exp_q);
        check_val("t3 err_code held", 32'(bus.err_code), 32'd1);
        check_val("t3 err count after", 32'(err_cnt - e0), 32'd1);

        // Requester 3 stalls mid-message: gap timeout, then demoted.
        do_reset();
        snd_en = 1'b1;
        rq[1].push_back({1'b1, 8'h10});
        wait_quiet("t4");
        e0 = err_cnt;
        rq[3].push_back({1'b0, 8'h44});
        wait_err("t4", e0);
        check_val("t4 err_code", 32'(bus.err_code), 32'd2);
        check_val("t4 gap cycles", 32'(err_cyc - fall_cyc), 32'(GAP_TMO) + 32'd1);
        check_val("t4 grant_vld", 32'(bus.grant_vld), 32'd0);
        gnt_log.delete();
        rq[3].push_back({1'b1, 8'h55});
        rq[1].push_back({1'b1, 8'h66});
        wait_quiet("t4b");
        check_val("t4 next gnt0", 32'(gnt_log.size() > 0 ? gnt_log[0] : 2'bxx), 32'd1);
        check_val("t4 next gnt1", 32'(gnt_log.size() > 1 ? gnt_log[1] : 2'bxx), 32'd3);
        check_val("t4 err count", 32'(err_cnt - e0), 32'd1);

        // Requester 2 single byte, with or without source tag.
        do_reset();
        snd_en = 1'b1;
        rq[2].push_back({1'b1, 8'h5A});
        wait_quiet("t5");
        exp_q.delete();
`ifdef UART_DEBUG_SRC_TAG_EN
        exp_q.push_back(8'hA2);
`endif
        exp_q.push_back(8'h5A);
        check_log("t5 log", exp_q);

        // Reset while in START.
        do_reset();
        e0 = err_cnt;
        rq[0].push_back({1'b1, 8'h3C});
        wait_start("t6");
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6");
        for (int i = 0; i < 4; i++) rq[i].delete();
        repeat (2) tick();
        rst_n = 1'b1;
        r0 = rdy_cnt[0] + rdy_cnt[1] + rdy_cnt[2] + rdy_cnt[3];
        repeat (6) tick();
        check_val("t6 no err", 32'(err_cnt - e0), 32'd0);
        check_val("t6 no ack", 32'(rdy_cnt[0] + rdy_cnt[1] + rdy_cnt[2] + rdy_cnt[3] - r0), 32'd0);
        check_val("t6 grant_vld", 32'(bus.grant_vld), 32'd0);

        check_val("ready violations", 32'(viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
